spike_event_fifo: RTL and testbench



---
 rtl/spike_event_fifo.sv | 92 +++++++++
 tb/tb_spike_event_fifo.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_event_fifo.sv
// Timestamps non-empty spike vectors and buffers {spike, ts} events in a
// first-word-fall-through FIFO with a valid/ready readout and drop statistics.
module spike_event_fifo #(
    parameter int unsigned TS_W  = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [7:0]                spike_in,
    output logic                      ev_valid,
    input  logic                      ev_ready,
    output logic [8+TS_W-1:0]         ev_data,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow,
    output logic [7:0]                drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned EW = 8 + TS_W;

    logic [TS_W-1:0] r_ts;
    logic [EW-1:0]   r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [LW-1:0]   r_level;
    logic            r_valid;
    logic            r_overflow;
    logic [7:0]      r_drop_cnt;

    logic            w_push_req;
    logic            w_pop;
    logic            w_full;
    logic            w_push;
    logic            w_drop;
    logic [LW-1:0]   w_level_nxt;

    // Push/pop arbitration; a pop on a full FIFO frees the slot for a same-edge push.
    always_comb begin
        w_push_req  = en && (spike_in != 8'h00);
        w_pop       = r_valid && ev_ready;
        w_full      = (r_level == LW'(DEPTH));
        w_push      = w_push_req && (!w_full || w_pop);
        w_drop      = w_push_req && w_full && !w_pop;
        w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ts       <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (en) begin
                r_ts <= r_ts + TS_W'(1);
            end
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_level <= w_level_nxt;
            r_valid <= (w_level_nxt != '0);
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 8'hFF) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end
        end
    end

    // Storage carries no reset; occupancy tracking alone defines validity.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wptr] <= {spike_in, r_ts};
        end
    end

    assign ev_valid = r_valid;
    assign ev_data  = r_mem[r_rptr];
    assign level    = r_level;
    assign overflow = r_overflow;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_spike_event_fifo.sv
// Scoreboard bench for spike_event_fifo: a 16-bit-timestamp instance for the
// main scenarios and a 4-bit-timestamp instance for wrap and mid-stream reset.
module tb_spike_event_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TS_W  = 16;
    localparam int unsigned EW    = 8 + TS_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst = 1'b1;
    logic           en = 1'b0;
    logic [7:0]     spike_in = 8'h00;
    logic           ev_valid;
    logic           ev_ready = 1'b0;
    logic [EW-1:0]  ev_data;
    logic [3:0]     level;
    logic           overflow;
    logic [7:0]     drop_cnt;

    logic           rst4 = 1'b1;
    logic           en4 = 1'b0;
    logic [7:0]     spike_in4 = 8'h00;
    logic           ev_valid4;
    logic           ev_ready4 = 1'b0;
    logic [11:0]    ev_data4;
    logic [3:0]     level4;
    logic           overflow4;
    logic [7:0]     drop_cnt4;

    spike_event_fifo #(.TS_W(TS_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .en(en), .spike_in(spike_in),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data),
        .level(level), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    spike_event_fifo #(.TS_W(4), .DEPTH(DEPTH)) dut4 (
        .clk(clk), .rst(rst4), .en(en4), .spike_in(spike_in4),
        .ev_valid(ev_valid4), .ev_ready(ev_ready4), .ev_data(ev_data4),
        .level(level4), .overflow(overflow4), .drop_cnt(drop_cnt4)
    );

    int checks = 0;
    int errors = 0;

    logic [EW-1:0] sb_q [$];
    logic [15:0]   m_ts;
    logic          m_ovf;
    int            m_drop;
    int            n_xfer;
    logic [EW-1:0] last_xfer;

    // Drives one cycle; checks the head against the scoreboard before the edge
    // and the statistics after it, updating the reference model in between.
    task automatic drive_cycle(input logic e, input logic [7:0] sp, input logic rdy);
        logic exp_valid;
        en = e;
        spike_in = sp;
        ev_ready = rdy;
        #1;
        exp_valid = (sb_q.size() != 0);
        checks++;
        if (ev_valid !== exp_valid) begin
            errors++;
            $display("FAIL ev_valid got %b expected %b at %0t", ev_valid, exp_valid, $time);
        end
        if (exp_valid) begin
            checks++;
            if (ev_data !== sb_q[0]) begin
                errors++;
                $display("FAIL ev_data got %h expected %h at %0t", ev_data, sb_q[0], $time);
            end
        end
        @(posedge clk);
        if (exp_valid && rdy) begin
            last_xfer = sb_q.pop_front();
            n_xfer++;
        end
        if (e && sp != 8'h00) begin
            if (sb_q.size() < DEPTH) sb_q.push_back({sp, m_ts});
            else begin
                m_ovf = 1'b1;
                if (m_drop < 255) m_drop++;
            end
        end
        if (e) m_ts = m_ts + 16'd1;
        @(negedge clk);
        checks++;
        if (level !== 4'(sb_q.size())) begin
            errors++;
            $display("FAIL level got %0d expected %0d at %0t", level, sb_q.size(), $time);
        end
        checks++;
        if (overflow !== m_ovf) begin
            errors++;
            $display("FAIL overflow got %b expected %b at %0t", overflow, m_ovf, $time);
        end
        checks++;
        if (drop_cnt !== 8'(m_drop)) begin
            errors++;
            $display("FAIL drop_cnt got %0d expected %0d at %0t", drop_cnt, m_drop, $time);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        en = 1'b0;
        spike_in = 8'h00;
        ev_ready = 1'b0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        m_ts = '0;
        m_ovf = 1'b0;
        m_drop = 0;
        n_xfer = 0;
        last_xfer = '0;
    endtask

    task automatic test_reset();
        do_reset(2);
        checks++;
        if (ev_valid !== 1'b0 || level !== 4'd0 || overflow !== 1'b0 || drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_state got valid=%b level=%0d ovf=%b drop=%0d expected 0/0/0/0",
                     ev_valid, level, overflow, drop_cnt);
        end
        for (int i = 0; i < 20; i++) drive_cycle(1'b1, 8'h00, 1'b1);
        checks++;
        if (dut.r_ts !== 16'd20) begin
            errors++;
            $display("FAIL idle_ts got %0d expected 20", dut.r_ts);
        end
    endtask

    task automatic test_single();
        do_reset(2);
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, (i == 3) ? 8'h05 : 8'h00, 1'b1);
        checks++;
        if (n_xfer != 1 || last_xfer !== {8'h05, 16'd3}) begin
            errors++;
            $display("FAIL single_event got %0d transfers last %h expected 1 transfer 05_0003",
                     n_xfer, last_xfer);
        end
    endtask

    task automatic test_backpressure();
        do_reset(2);
        for (int i = 0; i < 10; i++) drive_cycle(1'b1, 8'h00, 1'b0);
        drive_cycle(1'b1, 8'h01, 1'b0);
        drive_cycle(1'b1, 8'h02, 1'b0);
        drive_cycle(1'b1, 8'h04, 1'b0);
        drive_cycle(1'b0, 8'h00, 1'b0);
        checks++;
        if (level !== 4'd3 || ev_data !== {8'h01, 16'd10}) begin
            errors++;
            $display("FAIL backpressure_hold got level=%0d data=%h expected 3 and 01_000a",
                     level, ev_data);
        end
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 8'h00, 1'b1);
        checks++;
        if (n_xfer != 3 || last_xfer !== {8'h04, 16'd12}) begin
            errors++;
            $display("FAIL backpressure_drain got %0d transfers last %h expected 3 and 04_000c",
                     n_xfer, last_xfer);
        end
    endtask

    task automatic test_overflow();
        do_reset(2);
        for (int i = 0; i < 300; i++) drive_cycle(1'b1, 8'hFF, 1'b0);
        checks++;
        if (level !== 4'd8 || overflow !== 1'b1 || drop_cnt !== 8'd255 || ev_data !== {8'hFF, 16'd0}) begin
            errors++;
            $display("FAIL overflow_sat got level=%0d ovf=%b drop=%0d head=%h expected 8/1/255/ff_0000",
                     level, overflow, drop_cnt, ev_data);
        end
        for (int i = 0; i < 9; i++) drive_cycle(1'b0, 8'h00, 1'b1);
        checks++;
        if (n_xfer != 8 || last_xfer !== {8'hFF, 16'd7}) begin
            errors++;
            $display("FAIL overflow_drain got %0d transfers last %h expected 8 and ff_0007",
                     n_xfer, last_xfer);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset(2);
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, 8'hA5, 1'b0);
        for (int i = 0; i < 20; i++) drive_cycle(1'b1, 8'hA5, 1'b1);
        checks++;
        if (level !== 4'd8 || drop_cnt !== 8'd0 || last_xfer !== {8'hA5, 16'd19}) begin
            errors++;
            $display("FAIL full_push_pop got level=%0d drop=%0d last=%h expected 8/0/a5_0013",
                     level, drop_cnt, last_xfer);
        end
        for (int i = 0; i < 9; i++) drive_cycle(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_wrap_and_reset();
        @(negedge clk);
        rst4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst4 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            en4 = 1'b1;
            spike_in4 = 8'h03;
            ev_ready4 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (ev_valid4 !== 1'b1 || ev_data4 !== {8'h03, 4'(i)} || level4 !== 4'd1) begin
                errors++;
                $display("FAIL wrap_ts[%0d] got valid=%b data=%h level=%0d expected 1/%h/1",
                         i, ev_valid4, ev_data4, level4, {8'h03, 4'(i)});
            end
        end
        ev_ready4 = 1'b0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (level4 !== 4'd5 || ev_data4 !== {8'h03, 4'd3}) begin
            errors++;
            $display("FAIL wrap_buffer got level=%0d head=%h expected 5 and 033", level4, ev_data4);
        end
        rst4 = 1'b1;
        ev_ready4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (ev_valid4 !== 1'b0 || level4 !== 4'd0 || overflow4 !== 1'b0) begin
            errors++;
            $display("FAIL midstream_reset got valid=%b level=%0d ovf=%b expected 0/0/0",
                     ev_valid4, level4, overflow4);
        end
        rst4 = 1'b0;
        en4 = 1'b0;
        ev_ready4 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_full_push_pop();
        test_wrap_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
